// File: rtl/dcounter.sv
// 4-digit BCD up-counter with a short digit-clearing init phase.
// Counts once per clock while d_en is high and rdy is set.
module dcounter #(
  parameter int DIGITS      = 4,
  parameter int INIT_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  d_en,
  output logic [4*DIGITS-1:0]   d_out,
  output logic                  rdy
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    RUN  = 2'b01
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [4*DIGITS-1:0] out_n;
  logic                rdy_n;
  logic                carry;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      d_out <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d_out <= out_n;
      rdy   <= rdy_n;
    end
  end

  always_comb begin
    state_n = INIT;
    cnt_n   = cnt;
    out_n   = d_out;
    rdy_n   = 1'b0;
    carry   = 1'b0;
    case (state)
      INIT: begin
        cnt_n = cnt + CW'(1);
        for (int k = 0; k < DIGITS; k++) begin
          if (cnt == CW'(k))
            out_n[4*k +: 4] = 4'd0;
        end
        if (cnt == CW'(INIT_CYCLES - 1)) begin
          state_n = RUN;
          rdy_n   = 1'b1;
        end
      end
      RUN: begin
        state_n = RUN;
        rdy_n   = 1'b1;
        carry   = d_en;
        // Digits of 9 or above (illegal A-F too) roll to 0 and carry on.
        for (int k = 0; k < DIGITS; k++) begin
          if (carry) begin
            if (d_out[4*k +: 4] >= 4'd9) begin
              out_n[4*k +: 4] = 4'd0;
            end else begin
              out_n[4*k +: 4] = d_out[4*k +: 4] + 4'd1;
              carry           = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n = INIT;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcounter.sv
// Directed bench for dcounter: init sequence, decimal carries,
// wrap, hold and mid-count reset.
module tb_dcounter;

  logic        clock;
  logic        rst;
  logic        d_en;
  logic [15:0] d_out;
  logic        rdy;

  int n_cmp = 0;
  int n_bad = 0;

  dcounter dut (
    .clock (clock),
    .rst   (rst),
    .d_en  (d_en),
    .d_out (d_out),
    .rdy   (rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        r;
    logic        en;
    logic [15:0] q;
    logic        rd;
  } vec_t;

  vec_t vt [16];

  function automatic logic [15:0] bcd(int v);
    int w;
    w = v % 10000;
    return {4'(w / 1000), 4'((w / 100) % 10),
            4'((w / 10) % 10), 4'(w % 10)};
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read one full cycle later.
  task automatic tick(logic r, logic en);
    rst  = r;
    d_en = en;
    @(negedge clock);
  endtask

  initial begin
    int n;
    int i;
    rst  = 1'b1;
    d_en = 1'b0;

    vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 1'b1, 16'h0000, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'h0000, 1'b0};
    vt[4] = '{1'b0, 1'b1, 16'h0000, 1'b0};
    vt[5] = '{1'b0, 1'b1, 16'h0000, 1'b1};
    for (int j = 1; j <= 10; j++)
      vt[5 + j] = '{1'b0, 1'b1, bcd(j), 1'b1};

    for (int j = 0; j < 16; j++) begin
      tick(vt[j].r, vt[j].en);
      chk($sformatf("vec%0d_out", j), d_out, vt[j].q);
      chk($sformatf("vec%0d_rdy", j), {15'd0, rdy}, {15'd0, vt[j].rd});
    end

    // Long run through every decade boundary and the 9999 wrap.
    n = 10;
    while (n < 65536) begin
      tick(1'b0, 1'b1);
      n++;
      i = n % 10000;
      if (i == 99 || i == 100 || i == 999 || i == 1000 ||
          i == 9998 || i == 9999 || i == 0 || i == 1 ||
          n == 65536) begin
        chk($sformatf("run%0d_out", n), d_out, bcd(n));
        chk($sformatf("run%0d_rdy", n), {15'd0, rdy}, 16'd1);
      end
    end
    chk("cnt65536", d_out, 16'h5536);

    // Fresh start for hold and mid-count reset.
    tick(1'b1, 1'b0);
    chk("rst_out", d_out, 16'h0000);
    chk("rst_rdy", {15'd0, rdy}, 16'd0);
    i = 0;
    while (!rdy && i < 10) begin
      tick(1'b0, 1'b0);
      i++;
    end
    chk("init_len", 16'(i), 16'd4);
    for (int j = 0; j < 42; j++) tick(1'b0, 1'b1);
    chk("pre_hold", d_out, 16'h0042);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("hold%0d", j), d_out, 16'h0042);
    end
    tick(1'b0, 1'b1);
    chk("post_hold", d_out, 16'h0043);
    for (int j = 43; j < 1234; j++) tick(1'b0, 1'b1);
    chk("at1234", d_out, 16'h1234);

    tick(1'b1, 1'b1);
    chk("mid_rst_out", d_out, 16'h0000);
    chk("mid_rst_rdy", {15'd0, rdy}, 16'd0);
    for (int j = 1; j <= 3; j++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("reinit%0d_rdy", j), {15'd0, rdy}, 16'd0);
      chk($sformatf("reinit%0d_out", j), d_out, 16'h0000);
    end
    tick(1'b0, 1'b1);
    chk("reinit4_rdy", {15'd0, rdy}, 16'd1);
    chk("reinit4_out", d_out, 16'h0000);
    tick(1'b0, 1'b1);
    chk("resume1", d_out, 16'h0001);
    tick(1'b0, 1'b1);
    chk("resume2", d_out, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcounter.md
Name: dcounter

Overview:
- 4-digit BCD (decade) up-counter with an enable input and a ready flag.
- After synchronous reset, it runs a short initialisation sequence, asserts rdy, then increments the BCD value once per clock while d_en is high.
- Used as a simple free-running event/cycle counter whose 16-bit output reads directly as decimal when printed in hex.

Parameters:
- DIGITS, 4, number of BCD digits; output width is 4*DIGITS. The 16-bit port width requires DIGITS=4.
- INIT_CYCLES, 4, number of clock cycles spent in INIT after reset before rdy asserts. Must be ≥ DIGITS and ≥ 1.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- d_en  input  1  count enable; sampled only while rdy=1.
- d_out  output  16  current count, 4 packed BCD digits. [3:0] is units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- rdy  output  1  high once initialisation is complete and the counter accepts d_en.

Behaviour:
- One clock domain. Reset is synchronous and active-high; there is no asynchronous reset path.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (rst=1 at a rising edge):
  - state <= INIT, init counter <= 0, d_out <= 16'h0000, rdy <= 0.
  - Reset has priority over everything, including mid-count or mid-INIT. d_en is ignored during reset.
- State INIT:
  - The init counter increments each cycle.
  - On cycle k (k < DIGITS), digit k is written to 0 (d_out stays 0000).
  - When init counter reaches INIT_CYCLES-1: state <= RUN, rdy <= 1.
  - rdy therefore rises on the INIT_CYCLES-th rising edge with rst=0 (4th by default).
  - d_en is ignored in INIT.
- State RUN (rdy=1):
  - d_en=1 at an edge: d_out increments by one decimal unit.
    - Units digit increments. If it was 9 it becomes 0 and carries to tens, and so on through thousands.
    - 9999 -> 0000 wraps silently (no flag, no stall).
  - d_en=0: d_out holds.
  - rdy stays 1 until the next reset.
- Latency: d_en sampled high at edge N gives the new d_out visible after edge N (one-cycle register latency).
- Digits never take values A-F. Any illegal digit (not reachable from reset) is forced to 0 on its next increment, with carry treated as from 9.
- No other states. Unused state encodings return to INIT.

Test Plan:
- Reset/init: hold rst=1 for 2 cycles, d_en=0, then release.
  - Required: d_out=0000, rdy=0 during reset and for the first 3 edges after release.
  - rdy=1 after the 4th edge; d_out still 0000.
- Enable ignored before ready: d_en=1 from reset release.
  - Required: d_out=0000 until rdy=1.
  - First increment on the first edge with rdy=1 already high.
- Decimal carry: d_en=1 continuously from rdy.
  - Required sequence: 0000,0001,...,0009,0010.
  - After 99 counts: 0099 -> 0100. After 999 counts: 0999 -> 1000.
- Wrap: continue counting.
  - Required: 9998 -> 9999 -> 0000 -> 0001. rdy stays 1.
  - After 65536 enabled cycles, d_out=5536.
- Hold: from 0042, drop d_en for 5 cycles, then raise it.
  - Required: d_out stays 0042 for those cycles, then 0043 one edge after d_en returns high.
- Reset mid-operation: at d_out=1234 with d_en=1, assert rst for 1 cycle.
  - Required: d_out=0000 and rdy=0 after that edge.
  - INIT repeats (rdy=1 four edges after rst drops), then counting resumes from 0000.
